counter_checker: RTL and testbench

//  Receive-side partner of counter_datagen for the HPIO loopback test. Takes the
//  8-bit words the RX deserializer delivers to fabric, finds the word-boundary

---
 rtl/counter_checker.sv | 141 ++++++++++++++
 tb/tb_counter_checker.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : counter_checker                                            |
// | Description : HPIO loopback receive checker. Finds the word-boundary      |
// |               rotation of the deserialized stream, locks to the           |
// |               incrementing counter sequence and keeps error statistics.   |
// | Options     : CNT_CHECK_ROT_SEARCH_EN - when defined, a failed VERIFY      |
// |               steps the rotation; otherwise rot stays 0 and a failed      |
// |               VERIFY only reseeds (bitslip handled upstream).             |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module counter_checker #(
  parameter int DATA_W      = 8,
  parameter int LOCK_COUNT  = 16,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  input  logic              clr_stats,
  output logic              locked,
  output logic [2:0]        rot,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  word_count,
  output logic [CNT_W-1:0]  lock_loss_count
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_ERRS + 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_ERRS - 1);
`ifdef CNT_CHECK_ROT_SEARCH_EN
  localparam logic [2:0] ROT_LAST = 3'(DATA_W - 1);
`endif

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   expected;
  logic [GOOD_W-1:0]   good;
  logic [BAD_W-1:0]    bad;
  logic [2*DATA_W-1:0] doubled;
  logic [DATA_W-1:0]   aligned;
  logic                match;
  logic                word_evt;
  logic                err_evt;
  logic                loss_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Rotate the raw word left by rot and derive the per-word events for the stats.
  always_comb begin
    doubled  = {din, din} << rot;
    aligned  = doubled[2*DATA_W-1:DATA_W];
    match    = (aligned == expected);
    word_evt = din_valid && (state == ST_LOCKED);
    err_evt  = word_evt && !match;
    loss_evt = err_evt && (bad == BAD_LAST);
  end

  // Alignment / lock state machine; expected keeps running in LOCKED so a single
  // corrupt word costs exactly one error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_SEARCH;
      rot       <= '0;
      expected  <= '0;
      good      <= '0;
      bad       <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= err_evt;
      if (din_valid) begin
        case (state)
          ST_SEARCH: begin
            expected <= aligned + DATA_W'(1);
            good     <= '0;
            state    <= ST_VERIFY;
          end
          ST_VERIFY: begin
            if (match) begin
              expected <= expected + DATA_W'(1);
              good     <= good + GOOD_W'(1);
              if (good == GOOD_LAST) begin
                state  <= ST_LOCKED;
                locked <= 1'b1;
                bad    <= '0;
              end
            end else begin
`ifdef CNT_CHECK_ROT_SEARCH_EN
              rot <= (rot == ROT_LAST) ? 3'd0 : rot + 3'd1;
`endif
              state <= ST_SEARCH;
            end
          end
          ST_LOCKED: begin
            expected <= expected + DATA_W'(1);
            if (match) begin
              bad <= '0;
            end else if (bad == BAD_LAST) begin
              state  <= ST_SEARCH;
              locked <= 1'b0;
              bad    <= '0;
            end else begin
              bad <= bad + BAD_W'(1);
            end
          end
          default: begin
            state  <= ST_SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Saturating statistics; a clear request overrides a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_stats) begin
      err_count       <= '0;
      word_count      <= '0;
      lock_loss_count <= '0;
    end else begin
      if (word_evt) word_count      <= sat_inc(word_count);
      if (err_evt)  err_count       <= sat_inc(err_count);
      if (loss_evt) lock_loss_count <= sat_inc(lock_loss_count);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_counter_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_counter_checker                                         |
// | Description : Self-checking bench for counter_checker. A reference model |
// |               pushes the expected outputs for every driven cycle into a  |
// |               queue; they are popped and compared after the clock edge.  |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_counter_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din_valid = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        clr_stats = 1'b0;
  logic        locked;
  logic [2:0]  rot;
  logic        err_pulse;
  logic [31:0] err_count;
  logic [31:0] word_count;
  logic [31:0] lock_loss_count;

  counter_checker dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .din_valid       (din_valid),
    .din             (din),
    .clr_stats       (clr_stats),
    .locked          (locked),
    .rot             (rot),
    .err_pulse       (err_pulse),
    .err_count       (err_count),
    .word_count      (word_count),
    .lock_loss_count (lock_loss_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        lck;
    logic [2:0]  rt;
    logic        pls;
    logic [31:0] errc;
    logic [31:0] wc;
    logic [31:0] ll;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int pulses = 0;

  // reference model state: 0 SEARCH, 1 VERIFY, 2 LOCKED
  int          m_state = 0;
  logic [2:0]  m_rot = '0;
  logic [7:0]  m_exp = '0;
  int          m_good = 0;
  int          m_bad = 0;
  logic [31:0] m_err = '0;
  logic [31:0] m_wc = '0;
  logic [31:0] m_ll = '0;
  logic        m_pulse = 1'b0;
  logic [7:0]  cnt;

  function automatic logic [7:0] rotl(input logic [7:0] d, input logic [2:0] r);
    logic [7:0] o;
    o = '0;
    for (int i = 0; i < 8; i++) o[(i + int'(r)) % 8] = d[i];
    return o;
  endfunction

  function automatic logic [31:0] bump(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_step(input logic v, input logic [7:0] d, input logic c, input logic r);
    logic [7:0] a;
    m_pulse = 1'b0;
    if (!r) begin
      m_state = 0; m_rot = '0; m_exp = '0; m_good = 0; m_bad = 0;
      m_err = '0; m_wc = '0; m_ll = '0;
      return;
    end
    if (v) begin
      a = rotl(d, m_rot);
      if (m_state == 0) begin
        m_exp = a + 8'd1; m_good = 0; m_state = 1;
      end else if (m_state == 1) begin
        if (a == m_exp) begin
          m_good++; m_exp++;
          if (m_good == 16) begin m_state = 2; m_bad = 0; end
        end else begin
`ifdef CNT_CHECK_ROT_SEARCH_EN
          m_rot = m_rot + 3'd1;
`endif
          m_state = 0;
        end
      end else begin
        m_wc = bump(m_wc);
        if (a != m_exp) begin
          m_pulse = 1'b1;
          m_err = bump(m_err);
          m_bad++;
          if (m_bad == 4) begin m_state = 0; m_ll = bump(m_ll); end
        end else begin
          m_bad = 0;
        end
        m_exp++;
      end
    end
    if (c) begin m_err = '0; m_wc = '0; m_ll = '0; end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // drive one cycle, push the model's prediction, then pop and compare after the edge
  task automatic cycle(input logic v, input logic [7:0] d, input logic c, input logic r);
    exp_t e;
    din_valid = v; din = d; clr_stats = c; rst_n = r;
    model_step(v, d, c, r);
    e.lck = (m_state == 2); e.rt = m_rot; e.pls = m_pulse;
    e.errc = m_err; e.wc = m_wc; e.ll = m_ll;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pulses += int'(err_pulse);
    e = sb.pop_front();
    chk("sb_locked", 32'(locked), 32'(e.lck));
    chk("sb_rot", 32'(rot), 32'(e.rt));
    chk("sb_err_pulse", 32'(err_pulse), 32'(e.pls));
    chk("sb_err_count", err_count, e.errc);
    chk("sb_word_count", word_count, e.wc);
    chk("sb_lock_loss", lock_loss_count, e.ll);
  endtask

  task automatic send(input int n);
    for (int k = 0; k < n; k++) begin
      cycle(1'b1, cnt, 1'b0, 1'b1);
      cnt++;
    end
  endtask

  initial begin
    int nvalid;
    int seen_lock;
    logic v;
    cnt = 8'h00;

    // reset
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_counts", err_count | word_count | lock_loss_count, 32'd0);

    // aligned counter, lock after 17 words, clean across 0xFF->0x00
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, cnt, 1'b0, 1'b1);
      cnt++;
      if (i == 15) chk("t1_not_locked_yet", 32'(locked), 32'd0);
      if (i == 16) chk("t1_locked_after_17", 32'(locked), 32'd1);
    end
    chk("t1_rot", 32'(rot), 32'd0);
    chk("t1_err_count", err_count, 32'd0);
    chk("t1_word_count", word_count, 32'd283);

    // single corrupted word
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    pulses = 0;
    send(5);
    cycle(1'b1, cnt ^ 8'h01, 1'b0, 1'b1);
    cnt++;
    send(5);
    chk("t3_pulses", 32'(pulses), 32'd1);
    chk("t3_err_count", err_count, 32'd1);
    chk("t3_locked", 32'(locked), 32'd1);
    chk("t3_word_count", word_count, 32'd11);

    // skipped counter value -> 4 errors and loss of lock, then relock
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    pulses = 0;
    cnt++;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, cnt, 1'b0, 1'b1);
      cnt++;
      if (k == 2) chk("t4_still_locked", 32'(locked), 32'd1);
    end
    chk("t4_unlocked", 32'(locked), 32'd0);
    chk("t4_pulses", 32'(pulses), 32'd4);
    chk("t4_lock_loss", lock_loss_count, 32'd1);
    chk("t4_err_count", err_count, 32'd4);
    chk("t4_rot_kept", 32'(rot), 32'd0);
    for (int k = 0; k < 17; k++) begin
      cycle(1'b1, cnt, 1'b0, 1'b1);
      cnt++;
      if (k == 15) chk("t4_relock_not_yet", 32'(locked), 32'd0);
    end
    chk("t4_relocked", 32'(locked), 32'd1);

    // random valid gaps on a clean stream
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    nvalid = 0;
    pulses = 0;
    for (int k = 0; k < 200; k++) begin
      v = 1'($urandom_range(0, 1));
      if (v) begin
        cycle(1'b1, cnt, 1'b0, 1'b1);
        cnt++;
        nvalid++;
      end else begin
        cycle(1'b0, 8'hA5, 1'b0, 1'b1);
      end
    end
    chk("t5_word_count", word_count, 32'(nvalid));
    chk("t5_err_count", err_count, 32'd0);
    chk("t5_pulses", 32'(pulses), 32'd0);
    cycle(1'b1, cnt ^ 8'h10, 1'b1, 1'b1);
    cnt++;
    chk("t5_clr_err_count", err_count, 32'd0);
    chk("t5_clr_err_pulse", 32'(err_pulse), 32'd1);

    // rotated stream
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cnt = 8'h00;
    seen_lock = 0;
    for (int k = 0; k < 150; k++) begin
      cycle(1'b1, rotl(cnt, 3'd5), 1'b0, 1'b1);
      cnt++;
      if (locked) seen_lock = 1;
    end
`ifdef CNT_CHECK_ROT_SEARCH_EN
    chk("t2_rot", 32'(rot), 32'd3);
    chk("t2_locked", 32'(locked), 32'd1);
    chk("t2_err_count", err_count, 32'd0);
`else
    chk("t2_never_locked", 32'(seen_lock), 32'd0);
    chk("t2_rot_fixed", 32'(rot), 32'd0);
`endif

    // reset in the middle of VERIFY
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cnt = 8'h00;
    send(9);
    cycle(1'b1, cnt, 1'b0, 1'b0);
    chk("t6_locked", 32'(locked), 32'd0);
    chk("t6_rot", 32'(rot), 32'd0);
    chk("t6_pulse", 32'(err_pulse), 32'd0);
    chk("t6_counts", err_count | word_count | lock_loss_count, 32'd0);
    cnt = 8'h40;
    for (int k = 0; k < 17; k++) begin
      cycle(1'b1, cnt, 1'b0, 1'b1);
      cnt++;
      if (k == 15) chk("t6_not_locked_yet", 32'(locked), 32'd0);
    end
    chk("t6_relocked", 32'(locked), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
